// File: rtl/vpack_stream.sv
// vpack_stream: packs a valid/ready scalar stream into VECTOR_SIZE-lane vectors,
// padding short packets with PAD_VALUE so downstream reductions stay correct.
module vpack_stream #(
  parameter int VECTOR_SIZE = 16,
  parameter int INT_SIZE = 16,
  parameter logic [INT_SIZE-1:0] PAD_VALUE = '0
) (
  input  logic                                   clock,
  input  logic                                   resetn,
  input  logic [INT_SIZE-1:0]                    in_data,
  input  logic                                   in_valid,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]   out_vector,
  output logic [$clog2(VECTOR_SIZE):0]           out_count,
  output logic                                   out_last,
  output logic                                   out_valid,
  input  logic                                   out_ready
);
  localparam int IW = $clog2(VECTOR_SIZE);
  typedef enum logic {FILLING, HELD} state_t;
  state_t state, state_nxt;
  logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] fill, packed_vec;
  logic [IW-1:0] idx;
  logic [IW:0] held_count, count;
  logic held_last, accept, complete, slot_free, load;
  assign in_ready = state == FILLING;
  assign accept = in_valid && in_ready;
  assign complete = accept && (idx == IW'(VECTOR_SIZE - 1) || in_last);
  assign slot_free = !out_valid || out_ready;
  assign load = slot_free && (complete || state == HELD);
  assign count = state == HELD ? held_count : {1'b0, idx} + (IW + 1)'(1);
  // The completing beat bypasses the fill buffer so it can land in the slot on its own edge
  always_comb begin
    for (int k = 0; k < VECTOR_SIZE; k++)
      packed_vec[k] = (IW + 1)'(k) >= count ? PAD_VALUE : accept && IW'(k) == idx ? in_data : fill[k];
  end
  always_comb begin
    state_nxt = state == FILLING ? (complete && !slot_free ? HELD : FILLING) : (slot_free ? FILLING : HELD);
  end
  always_ff @(posedge clock)
    if (accept) fill[idx] <= in_data;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= FILLING;
      idx <= '0;
      held_count <= '0;
      held_last <= 1'b0;
      out_valid <= 1'b0;
      out_vector <= '0;
      out_count <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) idx <= complete ? '0 : idx + IW'(1);
      if (complete) begin
        held_count <= count;
        held_last <= in_last;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_vector <= packed_vec;
        out_count <= count;
        out_last <= state == HELD ? held_last : in_last;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/vpack_stream.md
# vpack_stream

Serial-to-parallel vector packer, directly upstream of the pipelined vector reduce-max stage. Accepts a stream of unsigned scalars over a valid/ready handshake, assembles them into VECTOR_SIZE-lane vectors, and presents each completed vector with valid/ready. A short packet, terminated early by in_last, is padded with PAD_VALUE so downstream reductions stay correct. Output width and lane order match the reduce-max input x, with lane 0 being the first scalar received.

## Interface
- VECTOR_SIZE, 16, lanes per vector; power of two, ≥2
- INT_SIZE, 16, bits per unsigned element
- PAD_VALUE, 0, value written to unfilled lanes of a short vector
- clock  input  1  clock; all logic on posedge
- resetn  input  1  reset, asynchronous, active-low
- in_data  input  INT_SIZE  scalar element
- in_valid  input  1  in_data valid
- in_last  input  1  final element of a packet; qualified by in_valid
- in_ready  output  1  block can accept a beat this cycle
- out_vector  output  [VECTOR_SIZE-1:0][INT_SIZE-1:0]  packed vector, lane 0 = first beat
- out_count  output  $clog2(VECTOR_SIZE)+1  number of real lanes, 1..VECTOR_SIZE
- out_last  output  1  vector ends a packet
- out_valid  output  1  out_* valid
- out_ready  input  1  downstream accepts the vector

## Operation
- Input beat accepted when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- Fill buffer: VECTOR_SIZE×INT_SIZE registers plus lane index idx, 0..VECTOR_SIZE-1. An accepted beat writes lane idx and increments idx.
- A vector completes on an accepted beat when idx==VECTOR_SIZE-1 or in_last==1.
- Output slot: a single register set holding out_vector, out_count, out_last and out_valid. The slot is free when !out_valid || out_ready.
- Fill FSM:
  - FILLING: in_ready=1. On a completing beat with the slot free, move the vector into the slot at the same edge, reset idx to 0, and stay in FILLING. On a completing beat with the slot not free, go to HELD.
  - HELD: in_ready=0. When the slot is free, move the held vector into the slot, reset idx to 0, and go to FILLING.
- Transfer into the slot:
  - Lanes < count take the buffered data, with the completing beat's data in its lane.
  - Lanes ≥ count take PAD_VALUE.
  - out_count = idx+1 of the completing beat; out_last = in_last of the completing beat.
- in_ready depends on FSM state only and never combinationally on out_ready or in_valid.
- A beat with in_last at lane VECTOR_SIZE-1 yields count=VECTOR_SIZE and out_last=1, with no extra vector.
- out_* must stay stable while out_valid && !out_ready.
- Slot clears (out_valid←0) on a transfer with no new vector moving in. A simultaneous drain and refill keeps out_valid=1 with new contents.
- in_data, in_last and in_valid are ignored when in_ready=0.
- Reset mid-packet discards the partial vector and any held or output vector.

## Timing
- Reset values:
  - state=FILLING, idx=0, in_ready=1
  - out_valid=0, out_vector=0, out_count=0, out_last=0
  - fill buffer is don't-care, as it is never visible
- Latency: completing beat accepted at edge N gives out_valid=1 in the cycle after edge N, when the slot is free.
- Throughput: one input beat per clock sustained while out_ready=1. A full vector is emitted every VECTOR_SIZE cycles.
- Backpressure: with out_ready=0, the block accepts one more full vector into the fill buffer, then enters HELD. in_ready deasserts in the cycle after the completing edge.
- From HELD, with out_ready rising in cycle M, the held vector transfers at edge M and in_ready=1 in cycle M+1.
- Handshake: in_valid and out_ready may toggle on any cycle. No combinational path exists from inputs to in_ready or out_*.

## Test plan
- Full vector: 16 beats, data 1..16, in_last on beat 16, out_ready=1 → one vector with lane k=k+1, out_count=16, out_last=1, out_valid exactly 1 cycle after the 16th accept.
- Short packet: beats 7, 3, 9 with in_last on 9 → lanes 0..2=7,3,9, lanes 3..15=0, out_count=3, out_last=1. The downstream max of this vector is 9.
- Back-to-back: 48 beats at full rate, data 0..47, in_last every 16, out_ready=1 → 3 vectors on consecutive 16-cycle boundaries, in_ready constantly 1, no dropped or duplicated lanes.
- Backpressure: out_ready=0 while 40 beats are offered → first vector in the slot, second HELD, in_ready=0 from the cycle after beat 32. Raising out_ready drains both in order and resumes input with beat 33 in lane 0.
- Multi-vector packet: 20 beats with in_last on beat 20 → vector 1 has count=16 and out_last=0. Vector 2 has count=4, lanes 4..15=PAD_VALUE, out_last=1.
- Reset mid-operation: assert resetn=0 after 5 beats and while an output is held → out_valid=0 immediately (asynchronous) and in_ready=1. After release, a 16-beat packet emits cleanly, with no residue from the 5 beats.
